// File: rtl/reset_seq_ctrl.sv
// -----------------------------------------------------------------------------
// reset_seq_ctrl
//   Multi-level reset sequencer. NUM_LVL active-low reset requests are
//   arbitrated by fixed priority (level 0 highest, the power-on class). The
//   winning level drives one output reset line, picked through LVL_MAP. Each
//   sequence is a check / assert / hold / release handshake against the line
//   status feedback, with a programmable settle delay per phase. An optional
//   watchdog aborts any timed phase whose status never settles, and the abort
//   is latched in a sticky error flag.
//
// Ports
//   clk         in   1        system clock
//   rst_n       in   1        asynchronous, active-low reset
//   req_n       in   NUM_LVL  reset requests, active low, level-held
//   cs_n        in   NUM_OUT  current status of each driven reset line
//   cs_stat_n   in   1        current status of RESETSTATz from the DSP
//   err_clr     in   1        clears err/err_lvl (single-cycle strobe)
//   rst_out_n   out  NUM_OUT  reset line drives, active low
//   busy        out  1        sequence in progress
//   active_lvl  out  3        level being serviced (valid while busy)
//   done        out  1        one-cycle pulse on normal completion
//   err         out  1        sticky watchdog abort flag
//   err_lvl     out  3        level being serviced when err was set
// -----------------------------------------------------------------------------
module reset_seq_ctrl #(
  parameter int unsigned          NUM_LVL = 4,
  parameter int unsigned          NUM_OUT = 3,
  parameter logic [8*NUM_LVL-1:0] LVL_MAP = 32'h02020100,
  parameter int unsigned          CNT_W   = 24,
  parameter logic [CNT_W-1:0]     CHK_DLY = 24'd1000,
  parameter logic [CNT_W-1:0]     AST_DLY = 24'd1000,
  parameter logic [CNT_W-1:0]     REL_DLY = 24'd1000,
  parameter logic [CNT_W-1:0]     TMO_CYC = 24'd0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_LVL-1:0] req_n,
  input  logic [NUM_OUT-1:0] cs_n,
  input  logic               cs_stat_n,
  input  logic               err_clr,
  output logic [NUM_OUT-1:0] rst_out_n,
  output logic               busy,
  output logic [2:0]         active_lvl,
  output logic               done,
  output logic               err,
  output logic [2:0]         err_lvl
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CHECK   = 3'd1,
    ST_ASSERT  = 3'd2,
    ST_HOLD    = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Lowest-index asserted request: {valid, index}.
  function automatic logic [3:0] pick_lvl(input logic [NUM_LVL-1:0] r);
    logic [3:0] res;
    res = 4'h0;
    for (int i = int'(NUM_LVL) - 1; i >= 0; i--) begin
      if (!r[i]) begin
        res = {1'b1, 3'(i)};
      end
    end
    return res;
  endfunction

  // Output line index mapped to a level; 8'hFF when the level is out of range.
  function automatic logic [7:0] line_of(input logic [2:0] l);
    logic [7:0] m;
    m = 8'hFF;
    for (int i = 0; i < int'(NUM_LVL); i++) begin
      if (l == 3'(i)) begin
        m = LVL_MAP[8*i +: 8];
      end
    end
    return m;
  endfunction

  // Line drive pattern with only line m low. A map entry beyond NUM_OUT
  // drives nothing, so at most one line is ever low.
  function automatic logic [NUM_OUT-1:0] line_mask(input logic [7:0] m);
    logic [NUM_OUT-1:0] v;
    v = '1;
    for (int j = 0; j < int'(NUM_OUT); j++) begin
      v[j] = (m != 8'(j));
    end
    return v;
  endfunction

  // Request bit of level l, read without a variable-width part select.
  function automatic logic req_at(input logic [NUM_LVL-1:0] r, input logic [2:0] l);
    logic v;
    v = 1'b1;
    for (int i = 0; i < int'(NUM_LVL); i++) begin
      if (l == 3'(i)) begin
        v = r[i];
      end
    end
    return v;
  endfunction

  state_t             state_r, state_s;
  logic [2:0]         lvl_r, lvl_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [CNT_W-1:0]   wdog_r, wdog_s;
  logic               abort_s;
  logic               done_s;
  logic               err_s;
  logic [2:0]         err_lvl_s;
  logic [NUM_OUT-1:0] rst_out_s;
  logic               busy_s;
  logic [2:0]         active_lvl_s;

  logic [3:0]         pick_s;
  logic [NUM_OUT-1:0] cur_mask_s;
  logic               all_high_s;
  logic               hold_ok_s;
  logic               rel_ok_s;
  logic               wdog_hit_s;

  assign pick_s     = pick_lvl(req_n);
  assign cur_mask_s = line_mask(line_of(lvl_r));
  assign all_high_s = &cs_n;
  assign hold_ok_s  = (cs_n == cur_mask_s) && !cs_stat_n;
  assign rel_ok_s   = all_high_s && cs_stat_n;
  // wdog holds the cycles already spent in the phase, so the current cycle
  // is number wdog+1; the phase is abandoned on its TMO_CYC-th cycle.
  assign wdog_hit_s = (TMO_CYC != CNT_ZERO) && (wdog_r >= (TMO_CYC - CNT_ONE));

  // Next-state, counter and registered-output next values.
  always_comb begin
    state_s = state_r;
    lvl_s   = lvl_r;
    cnt_s   = cnt_r;
    wdog_s  = wdog_r;
    abort_s = 1'b0;
    done_s  = 1'b0;

    case (state_r)
      ST_IDLE: begin
        cnt_s  = CNT_ZERO;
        wdog_s = CNT_ZERO;
        if (pick_s[3]) begin
          lvl_s   = pick_s[2:0];
          state_s = (pick_s[2:0] == 3'd0) ? ST_ASSERT : ST_CHECK;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_CHECK: begin
        if (pick_s[3] && (pick_s[2:0] < lvl_r)) begin
          // A higher-priority request restarts the check for that level.
          lvl_s   = pick_s[2:0];
          state_s = (pick_s[2:0] == 3'd0) ? ST_ASSERT : ST_CHECK;
          cnt_s   = CNT_ZERO;
          wdog_s  = CNT_ZERO;
        end else if (wdog_hit_s) begin
          abort_s = 1'b1;
        end else begin
          wdog_s = wdog_r + CNT_ONE;
          if (all_high_s) begin
            if (cnt_r >= CHK_DLY) begin
              state_s = ST_ASSERT;
              cnt_s   = CNT_ZERO;
            end else begin
              cnt_s = cnt_r + CNT_ONE;
            end
          end else begin
            cnt_s = CNT_ZERO;
          end
        end
      end

      ST_ASSERT: begin
        // The requester owns the length of this phase: no watchdog here.
        cnt_s  = CNT_ZERO;
        wdog_s = CNT_ZERO;
        if (req_at(req_n, lvl_r)) begin
          state_s = ST_HOLD;
        end else begin
          state_s = ST_ASSERT;
        end
      end

      ST_HOLD: begin
        if (wdog_hit_s) begin
          abort_s = 1'b1;
        end else begin
          wdog_s = wdog_r + CNT_ONE;
          if (hold_ok_s) begin
            if (cnt_r >= AST_DLY) begin
              state_s = ST_RELEASE;
              cnt_s   = CNT_ZERO;
              wdog_s  = CNT_ZERO;
            end else begin
              cnt_s = cnt_r + CNT_ONE;
            end
          end else begin
            cnt_s = CNT_ZERO;
          end
        end
      end

      ST_RELEASE: begin
        if (wdog_hit_s) begin
          abort_s = 1'b1;
        end else begin
          wdog_s = wdog_r + CNT_ONE;
          if (rel_ok_s) begin
            if (cnt_r >= REL_DLY) begin
              state_s = ST_IDLE;
              cnt_s   = CNT_ZERO;
              wdog_s  = CNT_ZERO;
              done_s  = 1'b1;
            end else begin
              cnt_s = cnt_r + CNT_ONE;
            end
          end else begin
            cnt_s = CNT_ZERO;
          end
        end
      end

      default: begin
        state_s = ST_IDLE;
        lvl_s   = 3'd0;
        cnt_s   = CNT_ZERO;
        wdog_s  = CNT_ZERO;
      end
    endcase

    if (abort_s) begin
      state_s = ST_IDLE;
      cnt_s   = CNT_ZERO;
      wdog_s  = CNT_ZERO;
    end else begin
      state_s = state_s;
    end

    // An abort in the same cycle as err_clr keeps the error set.
    if (abort_s) begin
      err_s     = 1'b1;
      err_lvl_s = lvl_r;
    end else if (err_clr) begin
      err_s     = 1'b0;
      err_lvl_s = 3'd0;
    end else begin
      err_s     = err;
      err_lvl_s = err_lvl;
    end

    // Outputs follow the next state so they change together with it.
    if ((state_s == ST_ASSERT) || (state_s == ST_HOLD)) begin
      rst_out_s = line_mask(line_of(lvl_s));
    end else begin
      rst_out_s = '1;
    end
    busy_s       = (state_s != ST_IDLE);
    active_lvl_s = busy_s ? lvl_s : 3'd0;
  end

  // Sequencer state, level and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      lvl_r   <= 3'd0;
      cnt_r   <= CNT_ZERO;
      wdog_r  <= CNT_ZERO;
    end else begin
      state_r <= state_s;
      lvl_r   <= lvl_s;
      cnt_r   <= cnt_s;
      wdog_r  <= wdog_s;
    end
  end

  // Registered outputs; reset releases every line immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_out_n  <= '1;
      busy       <= 1'b0;
      active_lvl <= 3'd0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_lvl    <= 3'd0;
    end else begin
      rst_out_n  <= rst_out_s;
      busy       <= busy_s;
      active_lvl <= active_lvl_s;
      done       <= done_s;
      err        <= err_s;
      err_lvl    <= err_lvl_s;
    end
  end

endmodule
